mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store unit directly upstream of Data_mem.
- Accepts byte-addressed load/store requests from the execute stage and converts them to word accesses on Data_mem's port (Data_address, Data_in, we, Data_out).
- Performs read-modify-write for byte and halfword stores and sign/zero extension for loads.
- Returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
MEM_WORDS, 2048, Data_mem depth in 32-bit words; any word index >= MEM_WORDS is an error.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
Req_valid  input  1  request present.
Req_ready  output  1  unit idle, request accepted this cycle if Req_valid.
Req_store  input  1  1 = store, 0 = load.
Req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
Req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
Req_addr  input  32  byte address.
Req_wdata  input  32  store data; byte/half taken from the low bits.
Rsp_valid  output  1  one-cycle completion pulse.
Rsp_rdata  output  32  extended load data; 0 for stores and errors.
Rsp_error  output  1  misaligned, reserved size, or out of range.
Mem_address  output  32  word index to Data_mem, equal to Req_addr[31:2] zero-extended.
Mem_data_in  output  32  write data to Data_mem.
Mem_we  output  1  write enable to Data_mem.
Mem_data_out  input  32  read data from Data_mem.

Behaviour:
- Clocking and reset:
  - Single clock Clk. Reset is synchronous and active-high.
  - Reset returns the FSM to IDLE and clears all request registers.
  - Reset values: Req_ready=1, Rsp_valid=0, Rsp_rdata=0, Rsp_error=0, Mem_address=0, Mem_data_in=0, Mem_we=0.
  - Reset mid-operation abandons the access; no Mem_we is issued after the reset edge.
- Data_mem contract:
  - Write commits on the rising edge where we=1.
  - Mem_data_out is valid the cycle after Mem_address is presented and held.
- Request acceptance:
  - Req_ready = (state == IDLE). A request is accepted on the edge where Req_valid && Req_ready.
  - All Req_* fields are registered at acceptance; inputs may change afterwards.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RESP.
  - IDLE to RESP: error detected at acceptance.
  - IDLE to WR: word store.
  - IDLE to RD_ADDR: load or sub-word store.
  - RD_ADDR to RD_DATA: always.
  - RD_DATA to RESP: load, data extracted and extended.
  - RD_DATA to WR: sub-word store, merge computed.
  - WR to RESP: always.
  - RESP to IDLE: always.
- Outputs by state:
  - Mem_address holds the registered word index in all non-IDLE states and is 0 in IDLE.
  - Mem_we=1 only in WR. Mem_data_in is the merged word in WR and 0 otherwise.
- Latency, counted as the number of edges from the acceptance edge to the edge that raises Rsp_valid:
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- Response:
  - Rsp_valid is high for exactly one cycle (state RESP). There is no backpressure.
  - The earliest next acceptance is the cycle after RESP.
- Errors: Req_size=11; half with addr[0]=1; word with addr[1:0]!=0; Req_addr[31:2] >= MEM_WORDS.
  - An erroring request produces no Data_mem access: Mem_we stays 0.
  - Response is Rsp_error=1 and Rsp_rdata=0.
- Byte lanes: little-endian.
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (0 selects bits 15:0, 1 selects bits 31:16).
- Merge: the read word with only the addressed lane replaced by Req_wdata[7:0] or Req_wdata[15:0]; all other bits are preserved.
- Load extension: replicate bit 7 or bit 15 when Req_signed=1, zeros otherwise. Word loads ignore Req_signed.
- Req_valid while busy is ignored; the requester must hold it until Req_ready.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- When defined, three output ports are added:
  - Load_count (16 bits): incremented on each successful load response.
  - Store_count (16 bits): incremented on each successful store response.
  - Error_count (16 bits): incremented on each error response.
  - All three reset to 0 and saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Word store 32'hDEADBEEF to addr 32'h00001000 (word 1024), then word load from the same address. Required: Mem_we high exactly one cycle with Mem_address=1024; load Rsp_rdata=32'hDEADBEEF, 3 edges after acceptance, Rsp_error=0.
- Preload word 1024 = 32'h11223344; byte store 8'hAA to addr 32'h00001002. Required: Mem_data_in=32'h11AA3344 during WR; response 4 edges after acceptance.
- With word 1024 = 32'h11AA3344: signed byte load at 0x1002 returns 32'hFFFFFFAA; unsigned byte load returns 32'h000000AA; signed half load at 0x1000 returns 32'h00003344.
- Word load at 0x1001, half load at 0x1003, Req_size=11, and a load at word 2048. Required for each: Rsp_error=1, Rsp_rdata=0, response 1 edge after acceptance, Mem_we never asserted.
- Reset asserted in the RD_DATA cycle of a sub-word store. Required: next cycle the FSM is in IDLE, Req_ready=1, Mem_we=0, and the target word is unchanged on readback.
- With MEM_ACCESS_STATS_EN defined: 3 loads, 2 stores, 1 error. Required: Load_count=3, Store_count=2, Error_count=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit in front of Data_mem: byte/half/word accesses, RMW for sub-word stores.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_unit #(
    parameter int MEM_WORDS = 2048
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic        Req_store,
    input  logic [1:0]  Req_size,
    input  logic        Req_signed,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Rsp_valid,
    output logic [31:0] Rsp_rdata,
    output logic        Rsp_error,
    output logic [31:0] Mem_address,
    output logic [31:0] Mem_data_in,
    output logic        Mem_we,
    input  logic [31:0] Mem_data_out
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0] Load_count,
    output logic [15:0] Store_count,
    output logic [15:0] Error_count
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]  r_state;
    logic        r_store;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_err;
    // Holds the word-store data, then the merged word in WR, or the extended load result in RESP.
    logic [31:0] r_data;

    logic        w_err;
    logic        w_oob;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge;

    assign w_oob = {2'b00, Req_addr[31:2]} >= 32'(MEM_WORDS);

    always_comb begin
        w_err = w_oob;
        case (Req_size)
            2'b01:   if (Req_addr[0]) w_err = 1'b1;
            2'b10:   if (Req_addr[1:0] != 2'b00) w_err = 1'b1;
            2'b11:   w_err = 1'b1;
            default: ;
        endcase
    end

    assign w_rd_byte = Mem_data_out[{r_addr[1:0], 3'b000} +: 8];
    assign w_rd_half = Mem_data_out[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = Mem_data_out;
        case (r_size)
            2'b00:   w_load_ext = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_load_ext = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
            default: ;
        endcase
    end

    always_comb begin
        w_merge = Mem_data_out;
        if (r_size == 2'b00)
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 16'd0;
            r_err    <= 1'b0;
            r_data   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Req_valid) begin
                        r_store  <= Req_store;
                        r_size   <= Req_size;
                        r_signed <= Req_signed;
                        r_addr   <= Req_addr;
                        r_wdata  <= Req_wdata[15:0];
                        r_err    <= w_err;
                        if (w_err) begin
                            r_data  <= 32'd0;
                            r_state <= RESP;
                        end else if (Req_store && Req_size == 2'b10) begin
                            r_data  <= Req_wdata;
                            r_state <= WR;
                        end else begin
                            r_data  <= 32'd0;
                            r_state <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: r_state <= RD_DATA;
                RD_DATA: begin
                    r_data  <= r_store ? w_merge : w_load_ext;
                    r_state <= r_store ? WR : RESP;
                end
                WR: begin
                    r_data  <= 32'd0;
                    r_state <= RESP;
                end
                RESP: begin
                    r_err   <= 1'b0;
                    r_data  <= 32'd0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Req_ready   = (r_state == IDLE);
    assign Rsp_valid   = (r_state == RESP);
    assign Rsp_error   = (r_state == RESP) && r_err;
    assign Rsp_rdata   = (r_state == RESP) ? r_data : 32'd0;
    assign Mem_address = (r_state != IDLE) ? {2'b00, r_addr[31:2]} : 32'd0;
    assign Mem_we      = (r_state == WR);
    assign Mem_data_in = (r_state == WR) ? r_data : 32'd0;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_load_cnt  <= 16'd0;
            r_store_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else if (r_state == RESP) begin
            if (r_err) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_store) begin
                if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
            end else begin
                if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
            end
        end
    end

    assign Load_count  = r_load_cnt;
    assign Store_count = r_store_cnt;
    assign Error_count = r_err_cnt;
`endif

endmodule
